// File: rtl/test_module_pkg.sv
// Shared types and constants for the timer/interrupt engine.
// Interrupt bit positions and the prescaler mask helper live here.
package test_module_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } tmr_state_e;

    localparam int unsigned INT_EXPIRE  = 0;
    localparam int unsigned INT_OVR     = 1;
    localparam int unsigned INT_RESTART = 2;
    localparam int unsigned INT_EXT     = 3;

    // Terminal prescaler count for a divide-by-2^div tick
    function automatic logic [2:0] div_mask(input logic [1:0] div);
        logic [3:0] m;
        m = (4'd1 << div) - 4'd1;
        return m[2:0];
    endfunction

endpackage

// File: rtl/test_module_prescaler.sv
// Prescaler: counts enabled pclk cycles while running and emits a tick every 2^div cycles.
// The divider setting is latched on clear and on each wrap, so changes apply at the next wrap.
module test_module_prescaler
    import test_module_pkg::*;
(
    input  logic       pclk,
    input  logic       hrst_n,
    input  logic       clk_en_i,
    input  logic       run_i,
    input  logic       clear_i,
    input  logic [1:0] div_i,
    output logic       tick_o
);

    logic [2:0] presc_q, presc_d;
    logic [1:0] div_q, div_d;

    assign tick_o = run_i & clk_en_i & (presc_q == div_mask(div_q));

    always_comb begin
        presc_d = presc_q;
        div_d   = div_q;
        if (clear_i) begin
            presc_d = '0;
            div_d   = div_i;
        end else if (run_i && clk_en_i) begin
            if (tick_o) begin
                presc_d = '0;
                div_d   = div_i;
            end else begin
                presc_d = presc_q + 3'd1;
            end
        end
    end

    always_ff @(posedge pclk or negedge hrst_n) begin
        if (!hrst_n) begin
            presc_q <= '0;
            div_q   <= '0;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/test_module_timer_core.sv
// Timer/interrupt engine: prescaled down-counter with run/pause/done control,
// sticky raw interrupt flags and a registered masked interrupt line.
module test_module_timer_core
    import test_module_pkg::*;
#(
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned NUM_INT     = 4,
    parameter bit          AUTO_RELOAD = 1'b1
) (
    input  logic               pclk,
    input  logic               hrst_n,
    input  logic               cfg_clk_en,
    input  logic [1:0]         cfg_clk_div,
    input  logic [CNT_W-1:0]   cfg_reload,
    input  logic               cfg_enable,
    input  logic               cfg_start,
    input  logic [NUM_INT-1:0] cfg_int_en,
    input  logic [NUM_INT-1:0] int_clr,
    input  logic               ext_evt,
    output logic [CNT_W-1:0]   tmr_value,
    output logic               tmr_busy,
    output logic [NUM_INT-1:0] int_raw,
    output logic               irq
);

    tmr_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_INT-1:0] int_raw_q, int_raw_d, int_set;
    logic               irq_q, irq_d;
    logic               start_q;
    logic [1:0]         ext_sync_q;
    logic               ext_q;

    logic start_rise, ext_rise, tick, load, expire, restart, run;

    assign start_rise = cfg_start & ~start_q;
    assign ext_rise   = ext_sync_q[1] & ~ext_q;
    // Prescaler only advances while the counter is actually counting
    assign run        = (state_q == RUN) & cfg_enable;

    test_module_prescaler u_presc (
        .pclk     (pclk),
        .hrst_n   (hrst_n),
        .clk_en_i (cfg_clk_en),
        .run_i    (run),
        .clear_i  (load),
        .div_i    (cfg_clk_div),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        expire  = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise && cfg_enable) begin
                    state_d = RUN;
                    count_d = cfg_reload;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    state_d = PAUSE;
                end else if (start_rise) begin
                    count_d = cfg_reload;
                    load    = 1'b1;
                    restart = 1'b1;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        expire = 1'b1;
                        if (AUTO_RELOAD) count_d = cfg_reload;
                        else             state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (cfg_enable) begin
                    state_d = RUN;
                    if (start_rise) begin
                        count_d = cfg_reload;
                        load    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                end else if (start_rise) begin
                    state_d = RUN;
                    count_d = cfg_reload;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set beats a same-cycle clear on every flag
    always_comb begin
        int_set              = '0;
        int_set[INT_EXPIRE]  = expire;
        int_set[INT_OVR]     = expire & int_raw_q[INT_EXPIRE] & ~int_clr[INT_EXPIRE];
        int_set[INT_RESTART] = restart;
        int_set[INT_EXT]     = ext_rise;
        int_raw_d            = (int_raw_q & ~int_clr) | int_set;
        irq_d                = |(int_raw_q & cfg_int_en);
    end

    always_ff @(posedge pclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            int_raw_q  <= '0;
            irq_q      <= 1'b0;
            start_q    <= 1'b0;
            ext_sync_q <= '0;
            ext_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            int_raw_q  <= int_raw_d;
            irq_q      <= irq_d;
            start_q    <= cfg_start;
            ext_sync_q <= {ext_sync_q[0], ext_evt};
            ext_q      <= ext_sync_q[1];
        end
    end

    assign tmr_value = count_q;
    assign tmr_busy  = (state_q == RUN);
    assign int_raw   = int_raw_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_test_module_timer_core.sv
// Directed bench for the timer core: a periodic and a one-shot instance share stimulus.
// Expected values are hand-derived cycle by cycle from the start/reset edges.
module tb_test_module_timer_core;

    logic       pclk;
    logic       hrst_n;
    logic       cfg_clk_en;
    logic [1:0] cfg_clk_div;
    logic [3:0] cfg_reload;
    logic       cfg_enable;
    logic       cfg_start;
    logic [3:0] cfg_int_en;
    logic [3:0] int_clr;
    logic       ext_evt;

    logic [3:0] tmr_value0, tmr_value1;
    logic       tmr_busy0, tmr_busy1;
    logic [3:0] int_raw0, int_raw1;
    logic       irq0, irq1;

    int n_checks;
    int n_fail;

    test_module_timer_core #(
        .CNT_W       (4),
        .NUM_INT     (4),
        .AUTO_RELOAD (1'b1)
    ) u_dut_periodic (
        .pclk        (pclk),
        .hrst_n      (hrst_n),
        .cfg_clk_en  (cfg_clk_en),
        .cfg_clk_div (cfg_clk_div),
        .cfg_reload  (cfg_reload),
        .cfg_enable  (cfg_enable),
        .cfg_start   (cfg_start),
        .cfg_int_en  (cfg_int_en),
        .int_clr     (int_clr),
        .ext_evt     (ext_evt),
        .tmr_value   (tmr_value0),
        .tmr_busy    (tmr_busy0),
        .int_raw     (int_raw0),
        .irq         (irq0)
    );

    test_module_timer_core #(
        .CNT_W       (4),
        .NUM_INT     (4),
        .AUTO_RELOAD (1'b0)
    ) u_dut_oneshot (
        .pclk        (pclk),
        .hrst_n      (hrst_n),
        .cfg_clk_en  (cfg_clk_en),
        .cfg_clk_div (cfg_clk_div),
        .cfg_reload  (cfg_reload),
        .cfg_enable  (cfg_enable),
        .cfg_start   (cfg_start),
        .cfg_int_en  (cfg_int_en),
        .int_clr     (int_clr),
        .ext_evt     (ext_evt),
        .tmr_value   (tmr_value1),
        .tmr_busy    (tmr_busy1),
        .int_raw     (int_raw1),
        .irq         (irq1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        hrst_n      = 1'b0;
        cfg_clk_en  = 1'b1;
        cfg_clk_div = 2'd0;
        cfg_reload  = 4'd0;
        cfg_enable  = 1'b0;
        cfg_start   = 1'b0;
        cfg_int_en  = 4'd0;
        int_clr     = 4'd0;
        ext_evt     = 1'b0;
        step(2);
        hrst_n = 1'b1;
        step(1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        check_eq("rst_value", {28'd0, tmr_value0}, 32'd0);
        check_eq("rst_busy", {31'd0, tmr_busy0}, 32'd0);
        check_eq("rst_int_raw", {28'd0, int_raw0}, 32'd0);
        check_eq("rst_irq", {31'd0, irq0}, 32'd0);

        // Periodic count, reload=3 div=0
        cfg_reload = 4'd3;
        cfg_enable = 1'b1;
        cfg_start  = 1'b1;
        step(1);
        check_eq("t1_busy", {31'd0, tmr_busy0}, 32'd1);
        check_eq("t1_val_e0", {28'd0, tmr_value0}, 32'd3);
        step(1);
        check_eq("t1_val_e1", {28'd0, tmr_value0}, 32'd2);
        step(1);
        check_eq("t1_val_e2", {28'd0, tmr_value0}, 32'd1);
        step(1);
        check_eq("t1_val_e3", {28'd0, tmr_value0}, 32'd0);
        check_eq("t1_raw_e3", {28'd0, int_raw0}, 32'd0);
        step(1);
        check_eq("t1_val_e4", {28'd0, tmr_value0}, 32'd3);
        check_eq("t1_raw_e4", {28'd0, int_raw0}, 32'd1);
        check_eq("t6_os_busy", {31'd0, tmr_busy1}, 32'd0);
        check_eq("t6_os_val", {28'd0, tmr_value1}, 32'd0);
        check_eq("t6_os_raw", {28'd0, int_raw1}, 32'd1);

        // Second expire without clear sets overrun
        step(4);
        check_eq("t3_ovr", {28'd0, int_raw0}, 32'd3);
        step(3);
        int_clr = 4'b0001;
        step(1);
        int_clr = 4'b0000;
        check_eq("t3_set_wins", {28'd0, int_raw0}, 32'd3);
        check_eq("t3_val_e12", {28'd0, tmr_value0}, 32'd3);
        int_clr = 4'b0011;
        step(1);
        int_clr = 4'b0000;
        check_eq("t3_cleared", {28'd0, int_raw0}, 32'd0);
        check_eq("t4_val_e13", {28'd0, tmr_value0}, 32'd2);

        // Pause at count 2, resume, then restart while busy
        cfg_enable = 1'b0;
        step(1);
        check_eq("t4_pause_busy", {31'd0, tmr_busy0}, 32'd0);
        step(10);
        check_eq("t4_pause_val", {28'd0, tmr_value0}, 32'd2);
        cfg_enable = 1'b1;
        step(1);
        check_eq("t4_resume_busy", {31'd0, tmr_busy0}, 32'd1);
        check_eq("t4_resume_val", {28'd0, tmr_value0}, 32'd2);
        step(1);
        check_eq("t4_resume_dec", {28'd0, tmr_value0}, 32'd1);
        cfg_start = 1'b0;
        step(1);
        check_eq("t4_val_zero", {28'd0, tmr_value0}, 32'd0);
        cfg_start = 1'b1;
        step(1);
        check_eq("t4_restart_val", {28'd0, tmr_value0}, 32'd3);
        check_eq("t4_restart_raw", {28'd0, int_raw0}, 32'd4);
        cfg_int_en = 4'b0100;
        step(1);
        check_eq("t4_irq", {31'd0, irq0}, 32'd1);

        // Asynchronous reset mid-run
        hrst_n = 1'b0;
        #1;
        check_eq("t6_arst_val", {28'd0, tmr_value0}, 32'd0);
        check_eq("t6_arst_busy", {31'd0, tmr_busy0}, 32'd0);
        check_eq("t6_arst_raw", {28'd0, int_raw0}, 32'd0);
        check_eq("t6_arst_irq", {31'd0, irq0}, 32'd0);

        // div=2, reload=1: 8-cycle period, 13 with 5 frozen cycles
        do_reset();
        cfg_clk_div = 2'd2;
        cfg_reload  = 4'd1;
        cfg_enable  = 1'b1;
        cfg_start   = 1'b1;
        step(1);
        check_eq("t2_val_e0", {28'd0, tmr_value0}, 32'd1);
        step(3);
        check_eq("t2_val_e3", {28'd0, tmr_value0}, 32'd1);
        step(1);
        check_eq("t2_val_e4", {28'd0, tmr_value0}, 32'd0);
        step(3);
        check_eq("t2_raw_e7", {28'd0, int_raw0}, 32'd0);
        step(1);
        check_eq("t2_raw_e8", {28'd0, int_raw0}, 32'd1);
        check_eq("t2_val_e8", {28'd0, tmr_value0}, 32'd1);
        int_clr = 4'b0001;
        step(1);
        int_clr    = 4'b0000;
        cfg_clk_en = 1'b0;
        step(5);
        cfg_clk_en = 1'b1;
        check_eq("t2_frozen_raw", {28'd0, int_raw0}, 32'd0);
        step(2);
        check_eq("t2_val_e16", {28'd0, tmr_value0}, 32'd1);
        step(1);
        check_eq("t2_val_e17", {28'd0, tmr_value0}, 32'd0);
        step(3);
        check_eq("t2_raw_e20", {28'd0, int_raw0}, 32'd0);
        step(1);
        check_eq("t2_raw_e21", {28'd0, int_raw0}, 32'd1);

        // External event through the synchroniser, then masking
        do_reset();
        cfg_int_en = 4'b1000;
        ext_evt    = 1'b1;
        step(1);
        ext_evt = 1'b0;
        check_eq("t5_raw_a", {28'd0, int_raw0}, 32'd0);
        step(1);
        check_eq("t5_raw_b", {28'd0, int_raw0}, 32'd0);
        step(1);
        check_eq("t5_raw_c", {28'd0, int_raw0}, 32'd8);
        check_eq("t5_irq_c", {31'd0, irq0}, 32'd0);
        step(1);
        check_eq("t5_irq_d", {31'd0, irq0}, 32'd1);
        cfg_int_en = 4'b0000;
        step(1);
        check_eq("t5_irq_masked", {31'd0, irq0}, 32'd0);
        check_eq("t5_raw_kept", {28'd0, int_raw0}, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
